// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier.
// State encoding and operand width used by controller and datapath.
package mul_pkg;

  localparam int OP_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mul_controller.sv
// Sequencing FSM for the repeated-addition multiplier.
// Loads A then B, adds until B reaches zero, pulses done.
module mul_controller
  import mul_pkg::*;
#(
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              eqz,
  output logic              LdA,
  output logic              LdB,
  output logic              clrP,
  output logic              LdP,
  output logic              decB,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt
);

  state_t              state_q, state_d;
  logic [ITER_W-1:0]   iter_q, iter_d;

  // State and iteration counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Next-state, strobes and counter update
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    in_ready = 1'b0;
    LdA      = 1'b0;
    LdB      = 1'b0;
    clrP     = 1'b0;
    LdP      = 1'b0;
    decB     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            LdA     = 1'b1;
            state_d = S_LOAD_B;
          end
        end
      end
      S_LOAD_B: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            LdB     = 1'b1;
            clrP    = 1'b1;
            iter_d  = '0;
            state_d = S_ADD;
          end
        end
      end
      S_ADD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (eqz) begin
          state_d = S_DONE;
        end else begin
          LdP    = 1'b1;
          decB   = 1'b1;
          iter_d = iter_q + ITER_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_mul_controller.sv
// Bench for mul_controller with a behavioural datapath.
// Scoreboard queue of expected completions checked on done.
module tb_mul_controller;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, in_valid, eqz;
  logic        in_ready, LdA, LdB, clrP, LdP, decB, busy, done;
  logic [15:0] iter_cnt;

  mul_controller #(.ITER_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .eqz(eqz),
    .LdA(LdA), .LdB(LdB), .clrP(clrP), .LdP(LdP), .decB(decB),
    .busy(busy), .done(done), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // datapath model
  logic [15:0] opa = '0, opb = '0, a_r = '0, b_r = '0;
  logic [31:0] p_r = '0;
  logic        sel = 1'b0;
  logic [15:0] data_in;
  assign data_in = sel ? opb : opa;
  assign eqz     = (b_r == 16'd0);

  always @(posedge clk) begin
    if (LdA) a_r <= data_in;
    if (LdB) b_r <= data_in;
    else if (decB) b_r <= b_r - 16'd1;
    if (clrP) p_r <= '0;
    else if (LdP) p_r <= p_r + {16'd0, a_r};
    if (LdA) sel <= 1'b1;
    else if (LdB || !busy) sel <= 1'b0;
  end

  typedef struct {
    logic [31:0] p;
    logic [15:0] iter;
    int          done_c;
    int          lda_c;
    int          ldb_c;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   lda_c = -1, ldb_c = -1, adds = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // monitor: strobe legality, event log, scoreboard pop on done
  always @(negedge clk) begin
    if (rst_n) begin
      chk("strobe_legal",
          32'({LdA, LdB, clrP, LdP, decB} inside
          {5'b00000, 5'b10000, 5'b01100, 5'b00011}), 32'd1);
      if (LdA) lda_c = cyc;
      if (LdB) begin ldb_c = cyc; adds = 0; end
      if (LdP) adds++;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", 32'(cyc),  32'(e.done_c));
          chk("lda_cycle",  32'(lda_c), 32'(e.lda_c));
          chk("ldb_cycle",  32'(ldb_c), 32'(e.ldb_c));
          chk("product",    p_r,        e.p);
          chk("iter_cnt",   32'(iter_cnt), 32'(e.iter));
          chk("add_count",  32'(adds),  32'(e.iter));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      step();
      n++;
    end
    if (q.size() > 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    step();
  endtask

  task automatic wait_chk();
    @(negedge clk);
    chk("stall_ready", 32'(in_ready), 32'd1);
    chk("stall_strb", 32'({LdA, LdB, clrP, LdP, decB}), 32'd0);
    step();
  endtask

  // one operation with sa/sb stall cycles before each operand
  task automatic op(input logic [15:0] a, input logic [15:0] b,
                    input int sa, input int sb, input bit wt);
    int c0;
    exp_t e;
    c0       = cyc;
    e.p      = 32'(a) * 32'(b);
    e.iter   = b;
    e.lda_c  = c0 + 1 + sa;
    e.ldb_c  = c0 + 2 + sa + sb;
    e.done_c = c0 + 4 + int'(b) + sa + sb;
    if (wt) q.push_back(e);
    opa = a; opb = b;
    start = 1'b1; in_valid = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < sa; i++) begin in_valid = 1'b0; wait_chk(); end
    in_valid = 1'b1;
    step();
    for (int i = 0; i < sb; i++) begin in_valid = 1'b0; wait_chk(); end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (wt) drain();
  endtask

  initial begin
    exp_t e;
    int   c0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    step(); step();
    @(negedge clk);
    chk("reset_outs", 32'({in_ready, LdA, LdB, clrP, LdP, decB,
                           busy, done}), 32'd0);
    chk("reset_iter", 32'(iter_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    op(16'd5, 16'd3, 0, 0, 1'b1);
    op(16'd7, 16'd0, 0, 0, 1'b1);
    op(16'd6, 16'd5, 4, 2, 1'b1);

    // abort in the second ADD cycle
    op(16'd4, 16'd10, 0, 0, 1'b0);
    step();
    abort = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("abort_strb", 32'({in_ready, LdA, LdB, clrP, LdP, decB}), 32'd0);
    step();
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'({busy, done, in_ready}), 32'd0);
    step();
    op(16'd2, 16'd2, 0, 0, 1'b1);

    // reset mid-ADD
    op(16'd9, 16'd8, 0, 0, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_outs", 32'({in_ready, LdA, LdB, clrP, LdP, decB,
                         busy, done}), 32'd0);
    chk("rst_iter", 32'(iter_cnt), 32'd0);
    step();
    op(16'd3, 16'd4, 0, 0, 1'b1);

    // start held high: back-to-back operations
    c0 = cyc;
    opa = 16'd3; opb = 16'd1;
    e.p = 32'd3; e.iter = 16'd1;
    e.lda_c = c0 + 1; e.ldb_c = c0 + 2; e.done_c = c0 + 5;
    q.push_back(e);
    e.lda_c = c0 + 7; e.ldb_c = c0 + 8; e.done_c = c0 + 11;
    q.push_back(e);
    start = 1'b1; in_valid = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk("b2b_idle_gap", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    drain();
    in_valid = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
